// File: rtl/ptp_pkg.sv
// ---------------------------------------------------------------------------
// ptp_pkg
// Shared definitions for the PTP event classifier:
//   - EtherType / IP / UDP constants used by the frame parser
//   - parser FSM state encoding
//   - fixed-width part of the timestamp record. The timestamp field width is
//     chosen per instance (TIME_W), so the full record struct is declared by
//     the user of this package as {ptp_rec_hdr_t, logic [TIME_W-1:0]}.
// ---------------------------------------------------------------------------
package ptp_pkg;

  localparam logic [15:0] ETH_VLAN     = 16'h8100;
  localparam logic [15:0] ETH_QINQ     = 16'h88A8;
  localparam logic [15:0] ETH_IPV4     = 16'h0800;
  localparam logic [15:0] ETH_PTP      = 16'h88F7;
  localparam logic [7:0]  IP_UDP       = 8'h11;
  localparam logic [7:0]  IPV4_VIHL    = 8'h45;   // version 4, 20-byte header
  localparam logic [15:0] PTP_EVT_PORT = 16'd319;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ETYPE,
    ST_IPV4,
    ST_PTPHDR,
    ST_SEQ,
    ST_MATCH,
    ST_SKIP
  } ptp_state_e;

  typedef struct packed {
    logic [15:0] seqid;
    logic [3:0]  msgid;
    logic        l2;
  } ptp_rec_hdr_t;

  // Both single (802.1Q) and service (802.1ad) tags are skipped the same way.
  function automatic logic is_vlan_tpid(input logic [15:0] etype);
    return (etype == ETH_VLAN) || (etype == ETH_QINQ);
  endfunction

endpackage

// File: rtl/ptp_classifier_if.sv
// ---------------------------------------------------------------------------
// ptp_classifier_if
// Packet bus into the classifier and record handshake out of it.
//   ptp_data/valid/sop/eop/mod : 32-bit big-endian packet words
//   ptp_time                   : free-running TSU time
//   rec_valid/rec_ready        : record handshake
//   rec_seqid/msgid/l2/time    : head record fields
//   drop_cnt                   : saturating count of records lost to a full FIFO
// master = packet source / record sink, slave = classifier.
// ---------------------------------------------------------------------------
interface ptp_classifier_if #(
  parameter int TIME_W = 30
);
  logic [31:0]       ptp_data;
  logic              ptp_valid;
  logic              ptp_sop;
  logic              ptp_eop;
  logic [1:0]        ptp_mod;
  logic [TIME_W-1:0] ptp_time;

  logic              rec_valid;
  logic              rec_ready;
  logic [15:0]       rec_seqid;
  logic [3:0]        rec_msgid;
  logic              rec_l2;
  logic [TIME_W-1:0] rec_time;
  logic [7:0]        drop_cnt;

  modport master (
    output ptp_data, ptp_valid, ptp_sop, ptp_eop, ptp_mod, ptp_time, rec_ready,
    input  rec_valid, rec_seqid, rec_msgid, rec_l2, rec_time, drop_cnt
  );

  modport slave (
    input  ptp_data, ptp_valid, ptp_sop, ptp_eop, ptp_mod, ptp_time, rec_ready,
    output rec_valid, rec_seqid, rec_msgid, rec_l2, rec_time, drop_cnt
  );
endinterface

// File: rtl/ptp_rec_fifo.sv
// ---------------------------------------------------------------------------
// ptp_rec_fifo
// Synchronous FIFO, DEPTH entries (power of two, >= 2) of WIDTH bits.
//   push/wdata : write request; ignored when full unless a pop happens too
//   pop        : read request; ignored when empty
//   rdata      : head entry, forced to zero while empty
//   full/empty : status flags
// ---------------------------------------------------------------------------
module ptp_rec_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;   // extra MSB tells full from empty
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still fits.
  assign do_push = push & (~full | do_pop);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define which
  // entries are live, and rdata is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ptp_classifier.sv
// ---------------------------------------------------------------------------
// ptp_classifier
// Classifies frames on the 32-bit packet bus as PTP event messages carried
// over UDP/IPv4 (or, with PTP_L2_EN defined, directly over Ethernet 0x88F7),
// skipping up to MAX_VLAN stacked VLAN tags. Matching frames push
// {sequenceId, messageType, transport, SOP time} into a record FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ptp_classifier_if.slave (packet input, record output,
//                drop_cnt)
// Build option: `define PTP_L2_EN enables L2 transport decode; otherwise
// 0x88F7 frames are skipped and rec_l2 is always 0.
// ---------------------------------------------------------------------------
module ptp_classifier
  import ptp_pkg::*;
#(
  parameter int          TIME_W     = 30,
  parameter int          HDR_WORDS  = 1,
  parameter int          MAX_VLAN   = 2,
  parameter logic [15:0] EVENT_MASK = 16'h000F,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ptp_classifier_if.slave bus
);
  typedef struct packed {
    ptp_rec_hdr_t      hdr;
    logic [TIME_W-1:0] ts;
  } rec_t;

  localparam int          REC_W    = $bits(rec_t);
  localparam logic [10:0] HDR_OFS  = 11'(HDR_WORDS);
  localparam logic [1:0]  VLAN_LIM = 2'(MAX_VLAN);

  // Word positions relative to the destination MAC, after tag removal.
  localparam logic [10:0] E_ETYPE   = 11'd3;
  localparam logic [10:0] E_PROTO   = 11'd5;
  localparam logic [10:0] E_PORT    = 11'd9;
  localparam logic [10:0] E_MSG     = 11'd10;
  localparam logic [10:0] E_SEQ_UDP = 11'd18;
  localparam logic [10:0] E_SEQ_L2  = 11'd11;

  // ---------------- input stage ----------------
  logic [31:0]       data_d1;
  logic [1:0]        mod_d1;
  logic              valid_d1, sop_d1, eop_d1;
  logic [TIME_W-1:0] ts_sop;
  logic [9:0]        widx;     // index of the word held in data_d1

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_d1  <= '0;
      mod_d1   <= '0;
      valid_d1 <= 1'b0;
      sop_d1   <= 1'b0;
      eop_d1   <= 1'b0;
      ts_sop   <= '0;
      widx     <= '0;
    end else begin
      valid_d1 <= bus.ptp_valid;
      sop_d1   <= bus.ptp_valid & bus.ptp_sop;
      eop_d1   <= bus.ptp_valid & bus.ptp_eop;
      if (bus.ptp_valid) begin
        data_d1 <= bus.ptp_data;
        mod_d1  <= bus.ptp_mod;
        if (bus.ptp_sop) begin
          widx   <= '0;
          ts_sop <= bus.ptp_time;
        end else if (widx != 10'h3FF) begin
          widx <= widx + 10'd1;
        end
      end
    end
  end

  // mod_d1 travels with the word for downstream consumers; parsing ignores it.
  logic unused_mod;
  assign unused_mod = ^mod_d1;

  // ---------------- parser ----------------
  ptp_state_e  state, state_nx;
  logic [1:0]  vofs, vofs_nx;
  logic [3:0]  msgid_q, msgid_nx;
  logic [15:0] seqid_q, seqid_nx;
  logic        l2_q, l2_nx;
  logic        push;

  logic [10:0] e_idx, seq_pos;
  logic [15:0] etype, hi16;
  logic [7:0]  vihl, proto;
  logic [3:0]  msg;

  // Before the MAC header e_idx wraps to a large value and matches nothing.
  assign e_idx   = {1'b0, widx} - HDR_OFS - {9'b0, vofs};
  assign etype   = data_d1[31:16];
  assign hi16    = data_d1[31:16];
  assign vihl    = data_d1[15:8];
  assign proto   = data_d1[7:0];
  assign msg     = data_d1[11:8];
  assign seq_pos = l2_q ? E_SEQ_L2 : E_SEQ_UDP;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_nx = state;
    vofs_nx  = vofs;
    msgid_nx = msgid_q;
    seqid_nx = seqid_q;
    l2_nx    = l2_q;
    push     = 1'b0;
    if (valid_d1) begin
      if (sop_d1) begin
        // A sop always starts a fresh frame; whatever was in flight is lost.
        state_nx = eop_d1 ? ST_IDLE : ST_ETYPE;
        vofs_nx  = '0;
        l2_nx    = 1'b0;
      end else if (eop_d1) begin
        push     = (state == ST_MATCH);
        state_nx = ST_IDLE;
      end else begin
        case (state)
          ST_ETYPE: if (e_idx == E_ETYPE) begin
            if (is_vlan_tpid(etype) && (vofs < VLAN_LIM)) begin
              // Shifting vofs moves the next word back onto e_idx == 3.
              vofs_nx = vofs + 2'd1;
            end else if ((etype == ETH_IPV4) && (vihl == IPV4_VIHL)) begin
              state_nx = ST_IPV4;
`ifdef PTP_L2_EN
            end else if (etype == ETH_PTP) begin
              msgid_nx = msg;
              l2_nx    = 1'b1;
              state_nx = EVENT_MASK[msg] ? ST_SEQ : ST_SKIP;
`endif
            end else begin
              state_nx = ST_SKIP;
            end
          end
          ST_IPV4: begin
            if ((e_idx == E_PROTO) && (proto != IP_UDP)) begin
              state_nx = ST_SKIP;
            end else if (e_idx == E_PORT) begin
              state_nx = (hi16 == PTP_EVT_PORT) ? ST_PTPHDR : ST_SKIP;
            end
          end
          ST_PTPHDR: if (e_idx == E_MSG) begin
            msgid_nx = msg;
            state_nx = EVENT_MASK[msg] ? ST_SEQ : ST_SKIP;
          end
          ST_SEQ: if (e_idx == seq_pos) begin
            seqid_nx = hi16;
            state_nx = ST_MATCH;
          end
          default: ;  // IDLE, MATCH, SKIP only leave on sop/eop
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      vofs    <= '0;
      msgid_q <= '0;
      seqid_q <= '0;
      l2_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      vofs    <= vofs_nx;
      msgid_q <= msgid_nx;
      seqid_q <= seqid_nx;
      l2_q    <= l2_nx;
    end
  end

  // ---------------- record FIFO ----------------
  rec_t             rec_in, head;
  logic [REC_W-1:0] head_bits;
  logic             fifo_full, fifo_empty, pop;
  logic [7:0]       drop_cnt;

  assign rec_in.hdr.seqid = seqid_q;
  assign rec_in.hdr.msgid = msgid_q;
  assign rec_in.hdr.l2    = l2_q;
  assign rec_in.ts        = ts_sop;
  assign pop              = ~fifo_empty & bus.rec_ready;

  ptp_rec_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (rec_in),
    .pop   (pop),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head = rec_t'(head_bits);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (push && fifo_full && !pop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign bus.rec_valid = ~fifo_empty;
  assign bus.rec_seqid = head.hdr.seqid;
  assign bus.rec_msgid = head.hdr.msgid;
  assign bus.rec_l2    = head.hdr.l2;
  assign bus.rec_time  = head.ts;
  assign bus.drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_ptp_classifier.sv
module tb_ptp_classifier;
  localparam int TIME_W = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  ptp_classifier_if #(.TIME_W(TIME_W)) bus ();

  ptp_classifier #(
    .TIME_W     (TIME_W),
    .HDR_WORDS  (1),
    .MAX_VLAN   (2),
    .EVENT_MASK (16'h000F),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0]       seqid;
    logic [3:0]        msgid;
    logic              l2;
    logic [TIME_W-1:0] t;
  } rec_s;

  rec_s        got[$];   // records accepted by the sink
  logic [31:0] fw[$];    // frame under construction, word 0 is the bus header

  always @(negedge clk)
    if (rst_n && bus.rec_valid && bus.rec_ready)
      got.push_back({bus.rec_seqid, bus.rec_msgid, bus.rec_l2, bus.rec_time});

  // Builds one frame into fw: header word, MACs, ntags tags (TPIDs taken from
  // the top of tpids), then UDP/IPv4 or L2 PTP with a 44-byte PTP message.
  task automatic build_frame(input int ntags, input logic [47:0] tpids, input bit l2,
                             input logic [15:0] dport, input logic [3:0] mtype,
                             input logic [15:0] seqid);
    logic [7:0]  b[$];
    logic [7:0]  ptp[44];
    logic [15:0] tp;
    b = {};
    for (int i = 0; i < 6; i++) b.push_back(8'h01 + 8'(i));
    for (int i = 0; i < 6; i++) b.push_back(8'h20 + 8'(i));
    for (int i = 0; i < ntags; i++) begin
      tp = tpids[47-16*i -: 16];
      b.push_back(tp[15:8]); b.push_back(tp[7:0]);
      b.push_back(8'h00);    b.push_back(8'h05);
    end
    for (int i = 0; i < 44; i++) ptp[i] = 8'h00;
    ptp[0]  = {4'h0, mtype};
    ptp[1]  = 8'h02;
    ptp[30] = seqid[15:8];
    ptp[31] = seqid[7:0];
    if (l2) begin
      b.push_back(8'h88); b.push_back(8'hF7);
    end else begin
      b.push_back(8'h08); b.push_back(8'h00);
      // IPv4: 45 00 len id flags ttl proto csum src dst
      b.push_back(8'h45); b.push_back(8'h00); b.push_back(8'h00); b.push_back(8'h48);
      b.push_back(8'h00); b.push_back(8'h00); b.push_back(8'h40); b.push_back(8'h00);
      b.push_back(8'h40); b.push_back(8'h11); b.push_back(8'h00); b.push_back(8'h00);
      b.push_back(8'hC0); b.push_back(8'hA8); b.push_back(8'h00); b.push_back(8'h01);
      b.push_back(8'hE0); b.push_back(8'h00); b.push_back(8'h01); b.push_back(8'h81);
      // UDP: sport 319, dport, len, csum
      b.push_back(8'h01); b.push_back(8'h3F);
      b.push_back(dport[15:8]); b.push_back(dport[7:0]);
      b.push_back(8'h00); b.push_back(8'h34); b.push_back(8'h00); b.push_back(8'h00);
    end
    for (int i = 0; i < 44; i++) b.push_back(ptp[i]);
    while ((b.size() % 4) != 0) b.push_back(8'h00);
    fw = {32'hA5A5_0001};
    for (int i = 0; i < b.size() / 4; i++)
      fw.push_back({b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]});
  endtask

  task automatic bus_idle();
    bus.ptp_valid = 1'b0;
    bus.ptp_sop   = 1'b0;
    bus.ptp_eop   = 1'b0;
    bus.ptp_mod   = 2'd0;
    bus.ptp_data  = 32'hDEAD_BEEF;
  endtask

  // Drives fw[first..last]; ptp_time on word i is t0 + i. Optional idle gaps.
  task automatic drive_words(input int first, input int last, input bit with_sop,
                             input bit with_eop, input logic [TIME_W-1:0] t0,
                             input bit gaps);
    for (int i = first; i <= last; i++) begin
      bus.ptp_data  = fw[i];
      bus.ptp_valid = 1'b1;
      bus.ptp_sop   = with_sop && (i == first);
      bus.ptp_eop   = with_eop && (i == last);
      bus.ptp_mod   = (with_eop && (i == last)) ? 2'd2 : 2'd0;
      bus.ptp_time  = t0 + TIME_W'(i);
      @(posedge clk); #1;
      if (gaps && (i % 3 == 1) && (i != last)) begin
        bus_idle();
        @(posedge clk); #1;
      end
    end
    bus_idle();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    wait_cycles(2);
    total++; if (bus.rec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.rec_valid); end
    total++; if (bus.rec_seqid !== 16'h0) begin bad++; $display("FAIL reset_seqid: got %h want 0000", bus.rec_seqid); end
    total++; if (bus.rec_msgid !== 4'h0) begin bad++; $display("FAIL reset_msgid: got %h want 0", bus.rec_msgid); end
    total++; if (bus.rec_l2 !== 1'b0) begin bad++; $display("FAIL reset_l2: got %b want 0", bus.rec_l2); end
    total++; if (bus.rec_time !== '0) begin bad++; $display("FAIL reset_time: got %h want 0", bus.rec_time); end
    total++; if (bus.drop_cnt !== 8'h0) begin bad++; $display("FAIL reset_drop: got %0d want 0", bus.drop_cnt); end
    rst_n = 1'b1;
    wait_cycles(2);
    total++; if (bus.rec_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid: got %b want 0", bus.rec_valid); end
  endtask

  task automatic test_sync();
    got.delete();
    build_frame(0, 48'h0, 1'b0, 16'd319, 4'd0, 16'h1234);
    drive_words(0, fw.size() - 1, 1'b1, 1'b1, 30'h100, 1'b0);
    @(negedge clk);  // cycle after eop: FIFO write still pending
    total++; if (bus.rec_valid !== 1'b0) begin bad++; $display("FAIL sync_early: rec_valid got %b want 0", bus.rec_valid); end
    @(negedge clk);  // two cycles after eop
    total++; if (bus.rec_valid !== 1'b1) begin bad++; $display("FAIL sync_latency: rec_valid got %b want 1", bus.rec_valid); end
    total++; if (bus.rec_seqid !== 16'h1234) begin bad++; $display("FAIL sync_seqid: got %h want 1234", bus.rec_seqid); end
    total++; if (bus.rec_msgid !== 4'd0) begin bad++; $display("FAIL sync_msgid: got %h want 0", bus.rec_msgid); end
    total++; if (bus.rec_l2 !== 1'b0) begin bad++; $display("FAIL sync_l2: got %b want 0", bus.rec_l2); end
    total++; if (bus.rec_time !== 30'h100) begin bad++; $display("FAIL sync_time: got %h want 100", bus.rec_time); end
    wait_cycles(3);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL sync_count: got %0d want 1", got.size()); end
  endtask

  task automatic test_vlan();
    got.delete();
    build_frame(2, {16'h8100, 16'h88A8, 16'h0}, 1'b0, 16'd319, 4'd2, 16'h0007);
    drive_words(0, fw.size() - 1, 1'b1, 1'b1, 30'h200, 1'b1);
    wait_cycles(4);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL vlan2_count: got %0d want 1", got.size()); end
    if (got.size() >= 1) begin
      total++; if (got[0].seqid !== 16'h0007) begin bad++; $display("FAIL vlan2_seqid: got %h want 0007", got[0].seqid); end
      total++; if (got[0].msgid !== 4'd2) begin bad++; $display("FAIL vlan2_msgid: got %h want 2", got[0].msgid); end
      total++; if (got[0].l2 !== 1'b0) begin bad++; $display("FAIL vlan2_l2: got %b want 0", got[0].l2); end
      total++; if (got[0].t !== 30'h200) begin bad++; $display("FAIL vlan2_time: got %h want 200", got[0].t); end
    end
    got.delete();
    build_frame(3, {16'h8100, 16'h88A8, 16'h8100}, 1'b0, 16'd319, 4'd2, 16'h0008);
    drive_words(0, fw.size() - 1, 1'b1, 1'b1, 30'h300, 1'b0);
    wait_cycles(4);
    total++; if (got.size() !== 0) begin bad++; $display("FAIL vlan3_count: got %0d want 0", got.size()); end
  endtask

  task automatic test_non_event();
    got.delete();
    build_frame(0, 48'h0, 1'b0, 16'd319, 4'd8, 16'h0101);   // Follow_Up
    drive_words(0, fw.size() - 1, 1'b1, 1'b1, 30'h400, 1'b0);
    build_frame(0, 48'h0, 1'b0, 16'd320, 4'd0, 16'h0102);   // Sync, general port
    drive_words(0, fw.size() - 1, 1'b1, 1'b1, 30'h500, 1'b0);
    wait_cycles(4);
    total++; if (got.size() !== 0) begin bad++; $display("FAIL nonevt_count: got %0d want 0", got.size()); end
    total++; if (bus.drop_cnt !== 8'd0) begin bad++; $display("FAIL nonevt_drop: got %0d want 0", bus.drop_cnt); end
  endtask

  task automatic test_l2();
    got.delete();
    build_frame(0, 48'h0, 1'b1, 16'd0, 4'd2, 16'hBEEF);     // Pdelay_Req over L2
    drive_words(0, fw.size() - 1, 1'b1, 1'b1, 30'h600, 1'b0);
    wait_cycles(4);
`ifdef PTP_L2_EN
    total++; if (got.size() !== 1) begin bad++; $display("FAIL l2_count: got %0d want 1", got.size()); end
    if (got.size() >= 1) begin
      total++; if (got[0].seqid !== 16'hBEEF) begin bad++; $display("FAIL l2_seqid: got %h want beef", got[0].seqid); end
      total++; if (got[0].msgid !== 4'd2) begin bad++; $display("FAIL l2_msgid: got %h want 2", got[0].msgid); end
      total++; if (got[0].l2 !== 1'b1) begin bad++; $display("FAIL l2_flag: got %b want 1", got[0].l2); end
    end
`else
    total++; if (got.size() !== 0) begin bad++; $display("FAIL l2_count: got %0d want 0", got.size()); end
`endif
  endtask

  task automatic test_back_to_back();
    got.delete();
    bus.rec_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      build_frame(0, 48'h0, 1'b0, 16'd319, 4'd1, 16'h0010 + 16'(k));
      drive_words(0, fw.size() - 1, 1'b1, 1'b1, 30'h1000 + 30'(k * 64), 1'b0);
    end
    wait_cycles(4);
    total++; if (bus.rec_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b want 1", bus.rec_valid); end
    total++; if (bus.drop_cnt !== 8'd2) begin bad++; $display("FAIL b2b_drop: got %0d want 2", bus.drop_cnt); end
    wait_cycles(3);
    total++; if (bus.rec_seqid !== 16'h0010) begin bad++; $display("FAIL b2b_head_stable: got %h want 0010", bus.rec_seqid); end
    total++; if (got.size() !== 0) begin bad++; $display("FAIL b2b_held: got %0d want 0", got.size()); end
    bus.rec_ready = 1'b1;
    wait_cycles(8);
    total++; if (got.size() !== 4) begin bad++; $display("FAIL b2b_drain_count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        total++;
        if (got[i].seqid !== 16'h0010 + 16'(i)) begin
          bad++; $display("FAIL b2b_order[%0d]: got %h want %h", i, got[i].seqid, 16'h0010 + 16'(i));
        end
      end
    end
    total++; if (bus.rec_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %b want 0", bus.rec_valid); end
  endtask

  task automatic test_abort();
    // Truncated at e=12 (word 13), then a good frame.
    got.delete();
    build_frame(0, 48'h0, 1'b0, 16'd319, 4'd0, 16'h2001);
    drive_words(0, 13, 1'b1, 1'b1, 30'h2000, 1'b0);
    build_frame(0, 48'h0, 1'b0, 16'd319, 4'd0, 16'h2002);
    drive_words(0, fw.size() - 1, 1'b1, 1'b1, 30'h2100, 1'b0);
    wait_cycles(4);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL trunc_count: got %0d want 1", got.size()); end
    if (got.size() >= 1) begin
      total++; if (got[0].seqid !== 16'h2002) begin bad++; $display("FAIL trunc_seqid: got %h want 2002", got[0].seqid); end
    end

    // New sop in the middle of a frame.
    got.delete();
    build_frame(0, 48'h0, 1'b0, 16'd319, 4'd0, 16'h3001);
    drive_words(0, 15, 1'b1, 1'b0, 30'h3000, 1'b0);
    build_frame(0, 48'h0, 1'b0, 16'd319, 4'd0, 16'h3002);
    drive_words(0, fw.size() - 1, 1'b1, 1'b1, 30'h3100, 1'b0);
    wait_cycles(4);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL midsop_count: got %0d want 1", got.size()); end
    if (got.size() >= 1) begin
      total++; if (got[0].seqid !== 16'h3002) begin bad++; $display("FAIL midsop_seqid: got %h want 3002", got[0].seqid); end
      total++; if (got[0].t !== 30'h3100) begin bad++; $display("FAIL midsop_time: got %h want 3100", got[0].t); end
    end

    // Reset mid-frame (after the sequenceId word), then the frame's tail.
    got.delete();
    build_frame(0, 48'h0, 1'b0, 16'd319, 4'd0, 16'h4001);
    drive_words(0, 20, 1'b1, 1'b0, 30'h4000, 1'b0);
    rst_n = 1'b0;
    #2;
    total++; if (bus.drop_cnt !== 8'd0) begin bad++; $display("FAIL rst_drop: got %0d want 0", bus.drop_cnt); end
    total++; if (bus.rec_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.rec_valid); end
    #1;
    rst_n = 1'b1;
    drive_words(21, fw.size() - 1, 1'b0, 1'b1, 30'h4000, 1'b0);
    build_frame(0, 48'h0, 1'b0, 16'd319, 4'd0, 16'h4002);
    drive_words(0, fw.size() - 1, 1'b1, 1'b1, 30'h4100, 1'b0);
    wait_cycles(4);
    total++; if (got.size() !== 1) begin bad++; $display("FAIL rstmid_count: got %0d want 1", got.size()); end
    if (got.size() >= 1) begin
      total++; if (got[0].seqid !== 16'h4002) begin bad++; $display("FAIL rstmid_seqid: got %h want 4002", got[0].seqid); end
    end
  endtask

  initial begin
    bus_idle();
    bus.ptp_time  = '0;
    bus.rec_ready = 1'b1;
    test_reset();
    test_sync();
    test_vlan();
    test_non_event();
    test_l2();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
